onehot_decoder_ctrl: RTL and testbench
======================================

// Module: onehot_decoder_ctrl
// PURPOSE
//   Registered N-to-2^N binary-to-one-hot decoder; inverse of the 8-to-3 priority encoder.
//   Codes enter on a valid/ready port and are buffered in a DEPTH-entry FIFO.
//   Each FIFO head is presented as a one-hot word on a valid/ready output port.
//   A built-in SCAN mode walks every code 0..2^N-1 through the same path for self-test of the encoder/decoder loop.
// PARAMETERS
//   N      3   code width; one-hot width W = 2**N
//   DEPTH  2   FIFO entries, power of 2, >= 2
// PORTS
//   clk           in   1    rising-edge clock
//   rst_n         in   1    synchronous active-low reset
//   en            in   1    global enable; 0 freezes accepts and scan (outputs held)
//   in_valid      in   1    in_code valid
//   in_ready      out  1    block accepts in_code this cycle
//   in_code       in   N    binary code to decode
//   scan_start    in   1    1-cycle pulse: start sweep of all codes
//   scan_busy     out  1    1 while in SCAN state
//   out_valid     out  1    out_onehot/out_code valid
//   out_ready     in   1    consumer takes head this cycle
//   out_onehot    out  W    one-hot of FIFO head; all-zero when out_valid=0
//   out_code      out  N    FIFO head code, echoed; 0 when out_valid=0
//   dec_count     out  8    saturating count of delivered words (valid&ready)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): FIFO emptied, state=IDLE, scan counter=0, dec_count=0.
//     out_valid, out_onehot, out_code and scan_busy are 0 from the next cycle.
//     in_ready is forced 0 while rst_n=0.
//     Reset mid-scan or mid-transfer discards everything; no partial output.
//   FSM (enum in package): IDLE, SCAN, DONE.
//     IDLE->SCAN: en & scan_start. SCAN ignores scan_start.
//     SCAN->DONE: after code W-1 is pushed. DONE->IDLE unconditionally after 1 cycle.
//   in_ready = rst_n & en & (state==IDLE) & !scan_start & !full. Combinational; no dependence on out_ready.
//   Push: in_valid & in_ready writes in_code. In SCAN: en & !full pushes scan counter, then counter increments.
//   Scan counter is N+1 bits; it is cleared on SCAN entry.
//   Pop: out_valid & out_ready. Push and pop in the same cycle are both performed; occupancy is unchanged.
//   Full: in_ready=0 and scan stalls. Empty: out_valid=0.
//   Pointers wrap modulo DEPTH.
//   Latency: code accepted at edge t gives out_valid=1 after edge t (1 cycle), when the FIFO was empty.
//   out_onehot = (1 << head) registered-path, exactly one bit set whenever out_valid=1.
//   Output stability: while out_valid & !out_ready, out_onehot and out_code are held unchanged.
//   en=0: no push and no scan advance. Pops still occur, so the consumer drains the FIFO.
//   dec_count increments on each pop and saturates at 255.
// STRUCTURE
//   Shared package decoder_pkg holds:
//     - state_t enum {IDLE, SCAN, DONE}
//     - default N
//     - localparam W = 1 << N
//   Sub-module code_fifo (params WIDTH, DEPTH):
//     - ports: push, pop, din, dout, full, empty
//     - dout is registered head
//   Top holds the FSM, scan counter, one-hot decode of dout, and dec_count.
// TESTING
//   Reset then idle: all outputs 0, in_ready=0 during reset, then 1.
//   Push in_code=3'd5 with out_ready=1: next cycle out_valid=1, out_onehot=8'b0010_0000, out_code=5, dec_count=1.
//   Backpressure, out_ready=0: push 1, 2. in_ready=0 on the third attempt (full).
//     out_onehot=8'h02 is held stable; release gives 8'h02 then 8'h04.
//   scan_start with out_ready=1: scan_busy for 8+ cycles.
//     Outputs 8'h01, 8'h02 ... 8'h80 in order, then DONE, then IDLE; dec_count=8.
//   Scan with en toggled low mid-sweep: sweep pauses, resumes, no code skipped or duplicated.
//   rst_n low during scan at code 4: all outputs 0 next cycle; a later scan restarts at 8'h01.

Source files
------------

// File: rtl/onehot_decoder_ctrl_pkg.sv
// Shared definitions for the one-hot decoder controller.
//   N_DEF   : default code width
//   W       : one-hot width for the default code width (1 << N_DEF)
//   state_t : sequencing states of the controller
package decoder_pkg;

  localparam int N_DEF = 3;
  localparam int W     = 1 << N_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_decoder_ctrl_if.sv
// Handshake bundle for the one-hot decoder controller.
//   in_valid / in_ready / in_code              : code input port
//   out_valid / out_ready / out_onehot / out_code : decoded output port
// master = the side that supplies codes and consumes one-hot words,
// slave  = the decoder itself.
interface onehot_decoder_ctrl_if
  import decoder_pkg::*;
#(
  parameter int N = N_DEF
);

  localparam int OH_W = 1 << N;

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_code;
  logic            out_valid;
  logic            out_ready;
  logic [OH_W-1:0] out_onehot;
  logic [N-1:0]    out_code;

  modport master (
    output in_valid,
    output in_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_onehot,
    input  out_code
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_onehot,
    output out_code
  );

endinterface

// File: rtl/onehot_decoder_ctrl_code_fifo.sv
// Small code FIFO with a registered head.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write din when not full
//   pop        : drop the head when not empty
//   dout       : registered head value, 0 while empty
//   full/empty : occupancy flags
module code_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = '0;

    // DEPTH is a power of two, so pointer overflow wraps naturally.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The next head is the word being written this cycle when the new read
    // pointer lands on the write slot (FIFO was empty, or drained to it).
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) dout_d = din;
      else                                   dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      if (push_ok) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/onehot_decoder_ctrl.sv
// Registered binary-to-one-hot decoder with a code FIFO and a self-test sweep.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : global enable; 0 freezes accepts and the sweep, pops continue
//   scan_start  : pulse, starts a sweep of every code 0..2^N-1
//   scan_busy   : high while sweeping
//   dec_count   : saturating count of delivered words
//   bus (slave) : code input and one-hot output handshakes
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting external codes, waiting for scan_start
// SCAN  | pushing the scan counter into the FIFO, one code per free slot
// DONE  | last scan code pushed; single settling cycle back to IDLE
module onehot_decoder_ctrl
  import decoder_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic [7:0]           dec_count,
  onehot_decoder_ctrl_if.slave bus
);

  localparam int             OH_W      = 1 << N;
  localparam logic [N:0]     SCAN_LAST = (N+1)'(OH_W - 1);
  localparam logic [OH_W-1:0] OH_ONE   = OH_W'(1);

  state_t         state_q, state_d;
  logic [N:0]     scan_cnt_q, scan_cnt_d;
  logic [7:0]     dec_count_q, dec_count_d;

  logic           scan_push;
  logic           in_push;
  logic           fifo_push;
  logic           fifo_pop;
  logic [N-1:0]   fifo_din;
  logic [N-1:0]   fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;

  assign bus.in_ready = rst_n & en & (state_q == IDLE) & ~scan_start & ~fifo_full;

  assign scan_push = (state_q == SCAN) & en & ~fifo_full;
  assign in_push   = bus.in_valid & bus.in_ready;
  assign fifo_push = in_push | scan_push;
  assign fifo_din  = scan_push ? scan_cnt_q[N-1:0] : bus.in_code;

  assign bus.out_valid = ~fifo_empty;
  assign fifo_pop      = bus.out_valid & bus.out_ready;

  // FIFO head is already zero when empty; the gate keeps the one-hot word
  // clean regardless.
  assign bus.out_code   = fifo_dout;
  assign bus.out_onehot = bus.out_valid ? (OH_ONE << fifo_dout) : '0;

  assign scan_busy = (state_q == SCAN);
  assign dec_count = dec_count_q;

  code_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    dec_count_d = dec_count_q;

    case (state_q)
      IDLE: begin
        if (en && scan_start) begin
          state_d    = SCAN;
          scan_cnt_d = '0;
        end
      end
      SCAN: begin
        if (scan_push) begin
          scan_cnt_d = scan_cnt_q + 1'b1;
          if (scan_cnt_q == SCAN_LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fifo_pop && (dec_count_q != 8'hFF)) dec_count_d = dec_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scan_cnt_q  <= '0;
      dec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      dec_count_q <= dec_count_d;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_ctrl.sv
// Self-checking bench for onehot_decoder_ctrl: a queue-based model is checked
// against the DUT every falling edge, plus directed literal expectations.
module tb_onehot_decoder_ctrl;

  localparam int N     = 3;
  localparam int W     = 1 << N;
  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       scan_start;
  logic       scan_busy;
  logic [7:0] dec_count;

  onehot_decoder_ctrl_if #(.N(N)) bus ();

  onehot_decoder_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .dec_count  (dec_count),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO contents as a queue, sweep as "active + next code".
  int q[$];
  bit m_scan = 0;
  bit m_done = 0;
  int m_next = 0;
  int m_cnt  = 0;
  bit m_room, m_acc, m_spush, m_pop;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_scan = 0;
      m_done = 0;
      m_next = 0;
      m_cnt  = 0;
    end else begin
      m_room  = (q.size() < DEPTH);
      m_acc   = en && !m_scan && !m_done && !scan_start && m_room && bus.in_valid;
      m_spush = m_scan && en && m_room;
      m_pop   = (q.size() > 0) && bus.out_ready;
      if (m_pop) begin
        void'(q.pop_front());
        if (m_cnt < 255) m_cnt++;
      end
      if (m_acc) q.push_back(int'(bus.in_code));
      if (m_done) m_done = 0;
      else if (m_scan) begin
        if (m_spush) begin
          q.push_back(m_next);
          m_next++;
          if (m_next == W) begin
            m_scan = 0;
            m_done = 1;
          end
        end
      end else if (en && scan_start) begin
        m_scan = 1;
        m_next = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_out_valid", bus.out_valid, (q.size() > 0) ? 1 : 0);
      chk("m_out_code", bus.out_code, (q.size() > 0) ? q[0] : 0);
      chk("m_out_onehot", bus.out_onehot, (q.size() > 0) ? (32'd1 << q[0]) : 0);
      chk("m_scan_busy", scan_busy, m_scan);
      chk("m_dec_count", dec_count, m_cnt);
      chk("m_in_ready", bus.in_ready,
          (rst_n && en && !m_scan && !m_done && !scan_start && (q.size() < DEPTH)) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int got[$];
  bit found;

  initial begin
    rst_n         = 1'b0;
    en            = 1'b1;
    scan_start    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;

    // Reset, then idle.
    step();
    cmp_en = 1;
    step();
    at_neg();
    chk("rst_in_ready", bus.in_ready, 0);
    step();
    rst_n = 1'b1;
    at_neg();
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_onehot", bus.out_onehot, 0);
    chk("idle_busy", scan_busy, 0);
    chk("idle_dec_count", dec_count, 0);

    // Single code 5 with consumer ready.
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd5;
    step();
    bus.in_valid = 1'b0;
    at_neg();
    chk("c5_valid", bus.out_valid, 1);
    chk("c5_onehot", bus.out_onehot, 32'h20);
    chk("c5_code", bus.out_code, 5);
    step();
    at_neg();
    chk("c5_dec_count", dec_count, 1);
    chk("c5_drained", bus.out_valid, 0);

    // Backpressure: fill with 1, 2, third attempt refused.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_code   = 3'd1;
    step();
    bus.in_code = 3'd2;
    step();
    bus.in_code = 3'd3;
    at_neg();
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_onehot", bus.out_onehot, 32'h02);
    step();
    bus.in_valid = 1'b0;
    step();
    at_neg();
    chk("held_onehot", bus.out_onehot, 32'h02);
    chk("held_code", bus.out_code, 1);
    step();
    bus.out_ready = 1'b1;
    at_neg();
    chk("rel0_onehot", bus.out_onehot, 32'h02);
    step();
    at_neg();
    chk("rel1_onehot", bus.out_onehot, 32'h04);
    step();
    at_neg();
    chk("rel_empty", bus.out_valid, 0);
    chk("rel_dec_count", dec_count, 3);

    // Fresh reset, then a full sweep with consumer ready.
    step();
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    at_neg();
    chk("scan_busy_on", scan_busy, 1);
    for (int k = 0; k < W; k++) begin
      step();
      at_neg();
      chk("scan_onehot", bus.out_onehot, 32'd1 << k);
      if (k == W - 1) chk("scan_busy_off", scan_busy, 0);
      else            chk("scan_busy_mid", scan_busy, 1);
    end
    step();
    at_neg();
    chk("scan_dec_count", dec_count, 8);
    chk("scan_idle_ready", bus.in_ready, 1);

    // Sweep with en dropped mid-way.
    step();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      at_neg();
      if (bus.out_valid) got.push_back(int'(bus.out_code));
      if (c == 4) chk("pause_busy", scan_busy, 1);
      step();
      if (c == 2) en = 1'b0;
      if (c == 6) en = 1'b1;
    end
    at_neg();
    chk("pause_busy_end", scan_busy, 0);
    chk("pause_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk("pause_seq", got[i], i);

    // Reset in the middle of a sweep while code 4 is presented.
    step();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      at_neg();
      if (bus.out_valid && bus.out_code == 3'd3) found = 1;
      else step();
    end
    chk("scan_reach3", found, 1);
    step();
    rst_n = 1'b0;
    at_neg();
    chk("mid_code4", bus.out_code, 4);
    chk("mid_rst_ready", bus.in_ready, 0);
    step();
    at_neg();
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_onehot", bus.out_onehot, 0);
    chk("mrst_code", bus.out_code, 0);
    chk("mrst_busy", scan_busy, 0);
    chk("mrst_dec_count", dec_count, 0);
    step();
    rst_n      = 1'b1;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step();
    at_neg();
    chk("restart_onehot", bus.out_onehot, 32'h01);
    repeat (12) step();
    at_neg();
    chk("restart_dec_count", dec_count, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
